load_store_unit: RTL and testbench

Parametrised data-side memory interface that replaces the single-cycle word RAM path.
- Accepts one RV32I load/store per request handshake: LB/LH/LW/LBU/LHU/SB/SH/SW selected by funct3.
- Serialises the access into little-endian beats on a narrow external valid/ready bus of BUS_DATA_WIDTH bits.
- Returns sign/zero-extended read data or an error; sits between the cpu datapath (alu_result address, register_read_data_2 store data) and the top-level pins.

---
 rtl/load_store_unit_pkg.sv | 42 ++++
 rtl/load_store_unit_byte_lane_aligner.sv | 52 +++++
 rtl/load_store_unit.sv | 152 +++++++++++++++
 tb/tb_load_store_unit.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 codes, FSM states
// and helpers that decode access size, alignment and legality.
package load_store_unit_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESPOND
  } lsu_state_e;

  // Bytes touched by an access; illegal encodings report 4 and are rejected elsewhere.
  function automatic logic [2:0] access_size(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (access_size(funct3))
      3'd1:    return 1'b0;
      3'd2:    return addr_lo[0];
      default: return |addr_lo;
    endcase
  endfunction

  function automatic logic is_illegal(input logic write, input logic [2:0] funct3);
    if (write) return !((funct3 == SB) || (funct3 == SH) || (funct3 == SW));
    return (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
  endfunction

endpackage

// File: rtl/load_store_unit_byte_lane_aligner.sv
// Combinational lane steering: places store bytes on the beat lanes with
// matching byte enables, and extracts/extends load data from the read buffer.
module byte_lane_aligner
  import load_store_unit_pkg::*;
#(
  parameter int BUS_DATA_WIDTH = 32
) (
  input  logic [2:0]                  funct3,
  input  logic [1:0]                  byte_offset,
  input  logic [1:0]                  beat,
  input  logic [31:0]                 store_data,
  input  logic [31:0]                 read_buffer,
  output logic [BUS_DATA_WIDTH/8-1:0] byte_enable,
  output logic [BUS_DATA_WIDTH-1:0]   write_data,
  output logic [31:0]                 load_data
);

  localparam int BUS_BYTES = BUS_DATA_WIDTH / 8;

  logic [1:0]  lane;
  logic [3:0]  enable_word;
  logic [31:0] shifted_store;
  logic [31:0] masked_store;
  logic [31:0] extracted;

  // Enables/data are first built across the whole 32-bit access, then the window for this beat is selected.
  always_comb begin
    lane          = byte_offset & 2'(BUS_BYTES - 1);
    enable_word   = 4'((5'd1 << access_size(funct3)) - 5'd1) << lane;
    shifted_store = store_data << {lane, 3'b000};
    masked_store  = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      masked_store[i*8 +: 8] = enable_word[i] ? shifted_store[i*8 +: 8] : 8'h00;
    end
    byte_enable = BUS_BYTES'(enable_word >> ({2'b00, beat} * 4'(BUS_BYTES)));
    write_data  = BUS_DATA_WIDTH'(masked_store >> ({5'b00000, beat} * 7'(BUS_DATA_WIDTH)));
  end

  // Load extraction from the lane the access started in, then sign/zero extension.
  always_comb begin
    extracted = read_buffer >> {lane, 3'b000};
    case (funct3)
      LB:      load_data = {{24{extracted[7]}}, extracted[7:0]};
      LH:      load_data = {{16{extracted[15]}}, extracted[15:0]};
      LW:      load_data = extracted;
      LBU:     load_data = {24'h000000, extracted[7:0]};
      LHU:     load_data = {16'h0000, extracted[15:0]};
      default: load_data = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-side memory interface: accepts one RV32I load/store, splits it into
// little-endian beats on a narrow valid/ready bus and returns extended data.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int BUS_ADDRESS_WIDTH = 32,
  parameter int BUS_DATA_WIDTH    = 32
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         request_valid,
  output logic                         request_ready,
  input  logic                         request_write,
  input  logic [2:0]                   request_funct3,
  input  logic [31:0]                  request_address,
  input  logic [31:0]                  request_write_data,
  output logic                         response_valid,
  output logic [31:0]                  response_read_data,
  output logic                         response_error,
  output logic                         bus_valid,
  input  logic                         bus_ready,
  output logic                         bus_write,
  output logic [BUS_ADDRESS_WIDTH-1:0] bus_address,
  output logic [BUS_DATA_WIDTH/8-1:0]  bus_byte_enable,
  output logic [BUS_DATA_WIDTH-1:0]    bus_write_data,
  input  logic [BUS_DATA_WIDTH-1:0]    bus_read_data
);

  localparam int BUS_BYTES = BUS_DATA_WIDTH / 8;
  localparam logic [31:0] LANE_ONES = {32{1'b1}} >> (32 - BUS_DATA_WIDTH);

  if (!(BUS_DATA_WIDTH == 8 || BUS_DATA_WIDTH == 16 || BUS_DATA_WIDTH == 32)) begin : g_bad_data_width
    $error("load_store_unit: BUS_DATA_WIDTH must be 8, 16 or 32");
  end
  if (BUS_ADDRESS_WIDTH < 2 || BUS_ADDRESS_WIDTH > 32) begin : g_bad_address_width
    $error("load_store_unit: BUS_ADDRESS_WIDTH must be in 2..32");
  end

  lsu_state_e                   state_q, state_d;
  logic [1:0]                   beat_q, beat_d;
  logic                         write_q, write_d;
  logic [2:0]                   funct3_q, funct3_d;
  logic [BUS_ADDRESS_WIDTH-1:0] address_q, address_d;
  logic [31:0]                  wdata_q, wdata_d;
  logic                         error_q, error_d;
  logic [31:0]                  buffer_q, buffer_d;

  logic [2:0]                   beat_count;
  logic                         last_beat;
  logic [6:0]                   buffer_shift;
  logic [BUS_BYTES-1:0]         lane_enable;
  logic [BUS_DATA_WIDTH-1:0]    lane_data;
  logic [31:0]                  load_data;

  byte_lane_aligner #(
    .BUS_DATA_WIDTH(BUS_DATA_WIDTH)
  ) u_aligner (
    .funct3     (funct3_q),
    .byte_offset(address_q[1:0]),
    .beat       (beat_q),
    .store_data (wdata_q),
    .read_buffer(buffer_q),
    .byte_enable(lane_enable),
    .write_data (lane_data),
    .load_data  (load_data)
  );

  // Beat bookkeeping: accesses narrower than the bus still take one beat.
  always_comb begin
    beat_count   = (access_size(funct3_q) > 3'(BUS_BYTES)) ? access_size(funct3_q) / 3'(BUS_BYTES) : 3'd1;
    last_beat    = ({1'b0, beat_q} + 3'd1) == beat_count;
    buffer_shift = {5'b00000, beat_q} * 7'(BUS_DATA_WIDTH);
  end

  // Next-state logic: capture on acceptance, collect beats, pulse the response.
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    write_d   = write_q;
    funct3_d  = funct3_q;
    address_d = address_q;
    wdata_d   = wdata_q;
    error_d   = error_q;
    buffer_d  = buffer_q;
    case (state_q)
      IDLE: begin
        if (request_valid) begin
          write_d   = request_write;
          funct3_d  = request_funct3;
          address_d = request_address[BUS_ADDRESS_WIDTH-1:0];
          wdata_d   = request_write_data;
          error_d   = is_illegal(request_write, request_funct3) ||
                      is_misaligned(request_funct3, request_address[1:0]);
          buffer_d  = '0;
          beat_d    = '0;
          state_d   = error_d ? RESPOND : ACCESS;
        end
      end
      ACCESS: begin
        if (bus_ready) begin
          buffer_d = (buffer_q & ~(LANE_ONES << buffer_shift)) | (32'(bus_read_data) << buffer_shift);
          if (last_beat) begin
            beat_d  = '0;
            state_d = RESPOND;
          end else begin
            beat_d = beat_q + 2'd1;
          end
        end
      end
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode from registered state only, so they are stable within a stalled beat.
  always_comb begin
    request_ready      = (state_q == IDLE);
    bus_valid          = (state_q == ACCESS);
    response_valid     = (state_q == RESPOND);
    bus_write          = bus_valid && write_q;
    bus_address        = bus_valid ? (address_q & ~BUS_ADDRESS_WIDTH'(BUS_BYTES - 1)) +
                                     BUS_ADDRESS_WIDTH'(beat_q) * BUS_ADDRESS_WIDTH'(BUS_BYTES) : '0;
    bus_byte_enable    = bus_valid ? lane_enable : '0;
    bus_write_data     = bus_write ? lane_data : '0;
    response_error     = response_valid && error_q;
    response_read_data = (response_valid && !write_q && !error_q) ? load_data : '0;
  end

  // State and captured request registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      beat_q    <= '0;
      write_q   <= 1'b0;
      funct3_q  <= '0;
      address_q <= '0;
      wdata_q   <= '0;
      error_q   <= 1'b0;
      buffer_q  <= '0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      write_q   <= write_d;
      funct3_q  <= funct3_d;
      address_q <= address_d;
      wdata_q   <= wdata_d;
      error_q   <= error_d;
      buffer_q  <= buffer_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: one 8-bit-bus and one 32-bit-bus
// instance (the latter with a 16-bit bus address), bus slaves checking beats
// against expected queues and a response monitor checking data/error/latency.
module tb_load_store_unit;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int unsigned checks = 0;
  int unsigned passes = 0;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        write;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int unsigned waits;
  } beat_t;

  typedef struct {
    logic [31:0] data;
    logic        error;
    int unsigned due;
  } resp_t;

  beat_t beats8[$], beats32[$];
  resp_t resp8[$], resp32[$];
  beat_t b8, b32;
  resp_t r8, r32;
  int unsigned wait8 = 0, wait32 = 0;

  // 8-bit bus instance
  logic        request_valid_8, request_ready_8, request_write_8;
  logic [2:0]  request_funct3_8;
  logic [31:0] request_address_8, request_write_data_8, response_read_data_8;
  logic        response_valid_8, response_error_8, bus_valid_8, bus_write_8;
  logic        bus_ready_8 = 1'b0;
  logic [31:0] bus_address_8;
  logic [0:0]  bus_byte_enable_8;
  logic [7:0]  bus_write_data_8;
  logic [7:0]  bus_read_data_8 = 8'h00;

  // 32-bit bus instance
  logic        request_valid_32, request_ready_32, request_write_32;
  logic [2:0]  request_funct3_32;
  logic [31:0] request_address_32, request_write_data_32, response_read_data_32;
  logic        response_valid_32, response_error_32, bus_valid_32, bus_write_32;
  logic        bus_ready_32 = 1'b0;
  logic [15:0] bus_address_32;
  logic [3:0]  bus_byte_enable_32;
  logic [31:0] bus_write_data_32;
  logic [31:0] bus_read_data_32 = 32'h0;

  load_store_unit #(.BUS_ADDRESS_WIDTH(32), .BUS_DATA_WIDTH(8)) u_lsu8 (
    .clock(clock), .reset(reset),
    .request_valid(request_valid_8), .request_ready(request_ready_8),
    .request_write(request_write_8), .request_funct3(request_funct3_8),
    .request_address(request_address_8), .request_write_data(request_write_data_8),
    .response_valid(response_valid_8), .response_read_data(response_read_data_8),
    .response_error(response_error_8),
    .bus_valid(bus_valid_8), .bus_ready(bus_ready_8), .bus_write(bus_write_8),
    .bus_address(bus_address_8), .bus_byte_enable(bus_byte_enable_8),
    .bus_write_data(bus_write_data_8), .bus_read_data(bus_read_data_8)
  );

  load_store_unit #(.BUS_ADDRESS_WIDTH(16), .BUS_DATA_WIDTH(32)) u_lsu32 (
    .clock(clock), .reset(reset),
    .request_valid(request_valid_32), .request_ready(request_ready_32),
    .request_write(request_write_32), .request_funct3(request_funct3_32),
    .request_address(request_address_32), .request_write_data(request_write_data_32),
    .response_valid(response_valid_32), .response_read_data(response_read_data_32),
    .response_error(response_error_32),
    .bus_valid(bus_valid_32), .bus_ready(bus_ready_32), .bus_write(bus_write_32),
    .bus_address(bus_address_32), .bus_byte_enable(bus_byte_enable_32),
    .bus_write_data(bus_write_data_32), .bus_read_data(bus_read_data_32)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  // 8-bit bus slave: checks each presented beat (every stalled cycle too) and completes it after its wait count.
  always @(negedge clock) begin
    bus_ready_8 = 1'b0;
    if (reset || !bus_valid_8) wait8 = 0;
    else if (beats8.size() == 0) check("bus8_unexpected_beat", 32'(bus_valid_8), 32'd0);
    else begin
      b8 = beats8[0];
      check("bus8_address", bus_address_8, b8.addr);
      check("bus8_byte_enable", 32'(bus_byte_enable_8), 32'(b8.be[0]));
      check("bus8_write", 32'(bus_write_8), 32'(b8.write));
      check("bus8_write_data", 32'(bus_write_data_8), b8.wdata);
      if (wait8 < b8.waits) wait8++;
      else begin
        bus_ready_8 = 1'b1;
        bus_read_data_8 = b8.rdata[7:0];
        void'(beats8.pop_front());
        wait8 = 0;
      end
    end
  end

  // 32-bit bus slave.
  always @(negedge clock) begin
    bus_ready_32 = 1'b0;
    if (reset || !bus_valid_32) wait32 = 0;
    else if (beats32.size() == 0) check("bus32_unexpected_beat", 32'(bus_valid_32), 32'd0);
    else begin
      b32 = beats32[0];
      check("bus32_address", 32'(bus_address_32), b32.addr);
      check("bus32_byte_enable", 32'(bus_byte_enable_32), 32'(b32.be));
      check("bus32_write", 32'(bus_write_32), 32'(b32.write));
      check("bus32_write_data", bus_write_data_32, b32.wdata);
      if (wait32 < b32.waits) wait32++;
      else begin
        bus_ready_32 = 1'b1;
        bus_read_data_32 = b32.rdata;
        void'(beats32.pop_front());
        wait32 = 0;
      end
    end
  end

  // Response monitors: every response must match the oldest expectation, including its cycle.
  always @(negedge clock) begin
    if (response_valid_8) begin
      if (resp8.size() == 0) check("resp8_unexpected", 32'(response_valid_8), 32'd0);
      else begin
        r8 = resp8.pop_front();
        check("resp8_data", response_read_data_8, r8.data);
        check("resp8_error", 32'(response_error_8), 32'(r8.error));
        check("resp8_latency", cyc, r8.due);
      end
    end
    if (response_valid_32) begin
      if (resp32.size() == 0) check("resp32_unexpected", 32'(response_valid_32), 32'd0);
      else begin
        r32 = resp32.pop_front();
        check("resp32_data", response_read_data_32, r32.data);
        check("resp32_error", 32'(response_error_32), 32'(r32.error));
        check("resp32_latency", cyc, r32.due);
      end
    end
  end

  task automatic beat(input int unsigned dut, input logic [31:0] addr, input logic [3:0] be,
                      input logic w, input logic [31:0] wd, input logic [31:0] rd, input int unsigned waits);
    beat_t b;
    b.addr = addr; b.be = be; b.write = w; b.wdata = wd; b.rdata = rd; b.waits = waits;
    if (dut == 8) beats8.push_back(b);
    else beats32.push_back(b);
  endtask

  task automatic drive(input int unsigned dut, input logic w, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd);
    if (dut == 8) begin
      check("req8_ready", 32'(request_ready_8), 32'd1);
      request_valid_8 = 1'b1; request_write_8 = w; request_funct3_8 = f3;
      request_address_8 = addr; request_write_data_8 = wd;
    end else begin
      check("req32_ready", 32'(request_ready_32), 32'd1);
      request_valid_32 = 1'b1; request_write_32 = w; request_funct3_32 = f3;
      request_address_32 = addr; request_write_data_32 = wd;
    end
  endtask

  // Issues one request, records its expected response and waits (bounded) for it to be consumed.
  task automatic issue(input int unsigned dut, input logic w, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_data, input logic exp_err, input int unsigned lat);
    resp_t r;
    @(negedge clock);
    r.data = exp_data; r.error = exp_err; r.due = cyc + 1 + lat;
    if (dut == 8) resp8.push_back(r);
    else resp32.push_back(r);
    drive(dut, w, f3, addr, wd);
    @(posedge clock);
    #1;
    request_valid_8 = 1'b0;
    request_valid_32 = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if ((dut == 8) ? (resp8.size() == 0) : (resp32.size() == 0)) break;
      @(negedge clock);
    end
    if (dut == 8) begin
      if (resp8.size() != 0) begin check("resp8_timeout", resp8.size(), 32'd0); resp8.delete(); end
    end else begin
      if (resp32.size() != 0) begin check("resp32_timeout", resp32.size(), 32'd0); resp32.delete(); end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    request_valid_8 = 1'b0; request_write_8 = 1'b0; request_funct3_8 = '0;
    request_address_8 = '0; request_write_data_8 = '0;
    request_valid_32 = 1'b0; request_write_32 = 1'b0; request_funct3_32 = '0;
    request_address_32 = '0; request_write_data_32 = '0;
    @(negedge clock);
    check("rst_request_ready8", 32'(request_ready_8), 32'd1);
    check("rst_bus_valid8", 32'(bus_valid_8), 32'd0);
    check("rst_response_valid8", 32'(response_valid_8), 32'd0);
    check("rst_request_ready32", 32'(request_ready_32), 32'd1);
    check("rst_bus_address32", 32'(bus_address_32), 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // 8-bit bus: word store split into four byte beats
    beat(8, 32'h10, 4'h1, 1'b1, 32'h44, 32'h0, 0);
    beat(8, 32'h11, 4'h1, 1'b1, 32'h33, 32'h0, 0);
    beat(8, 32'h12, 4'h1, 1'b1, 32'h22, 32'h0, 0);
    beat(8, 32'h13, 4'h1, 1'b1, 32'h11, 32'h0, 0);
    issue(8, 1'b1, 3'b010, 32'h10, 32'h11223344, 32'h0, 1'b0, 4);
    // byte loads, signed and unsigned
    beat(8, 32'h13, 4'h1, 1'b0, 32'h0, 32'h80, 0);
    issue(8, 1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0, 1);
    beat(8, 32'h13, 4'h1, 1'b0, 32'h0, 32'h80, 0);
    issue(8, 1'b0, 3'b100, 32'h13, 32'h0, 32'h00000080, 1'b0, 1);
    // errors: misaligned half, illegal funct3 load, unsigned-store encoding
    issue(8, 1'b0, 3'b001, 32'h11, 32'h0, 32'h0, 1'b1, 0);
    issue(8, 1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, 0);
    issue(8, 1'b1, 3'b100, 32'h10, 32'hFF, 32'h0, 1'b1, 0);
    // half store/load over two beats
    beat(8, 32'h20, 4'h1, 1'b1, 32'hEF, 32'h0, 0);
    beat(8, 32'h21, 4'h1, 1'b1, 32'hBE, 32'h0, 0);
    issue(8, 1'b1, 3'b001, 32'h20, 32'hCAFEBEEF, 32'h0, 1'b0, 2);
    beat(8, 32'h22, 4'h1, 1'b0, 32'h0, 32'h34, 0);
    beat(8, 32'h23, 4'h1, 1'b0, 32'h0, 32'hF2, 0);
    issue(8, 1'b0, 3'b001, 32'h22, 32'h0, 32'hFFFFF234, 1'b0, 2);
    // word load with three wait states on beat 2
    beat(8, 32'h40, 4'h1, 1'b0, 32'h0, 32'h78, 0);
    beat(8, 32'h41, 4'h1, 1'b0, 32'h0, 32'h56, 0);
    beat(8, 32'h42, 4'h1, 1'b0, 32'h0, 32'h34, 3);
    beat(8, 32'h43, 4'h1, 1'b0, 32'h0, 32'h12, 0);
    issue(8, 1'b0, 3'b010, 32'h40, 32'h0, 32'h12345678, 1'b0, 7);

    // reset during a stalled beat 2 of a word store: abandoned with no response
    beat(8, 32'h50, 4'h1, 1'b1, 32'hD4, 32'h0, 0);
    beat(8, 32'h51, 4'h1, 1'b1, 32'hC3, 32'h0, 0);
    beat(8, 32'h52, 4'h1, 1'b1, 32'hB2, 32'h0, 20);
    beat(8, 32'h53, 4'h1, 1'b1, 32'hA1, 32'h0, 0);
    @(negedge clock);
    drive(8, 1'b1, 3'b010, 32'h50, 32'hA1B2C3D4);
    @(posedge clock);
    #1 request_valid_8 = 1'b0;
    repeat (3) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    check("midrst_bus_valid8", 32'(bus_valid_8), 32'd0);
    check("midrst_response_valid8", 32'(response_valid_8), 32'd0);
    check("midrst_bus_address8", bus_address_8, 32'd0);
    check("midrst_beats_done", beats8.size(), 32'd2);
    beats8.delete();
    @(negedge clock);
    reset = 1'b0;
    #1 check("postrst_request_ready8", 32'(request_ready_8), 32'd1);
    beat(8, 32'h60, 4'h1, 1'b0, 32'h0, 32'h01, 0);
    beat(8, 32'h61, 4'h1, 1'b0, 32'h0, 32'h02, 0);
    beat(8, 32'h62, 4'h1, 1'b0, 32'h0, 32'h03, 0);
    beat(8, 32'h63, 4'h1, 1'b0, 32'h0, 32'h84, 0);
    issue(8, 1'b0, 3'b010, 32'h60, 32'h0, 32'h84030201, 1'b0, 4);

    // 32-bit bus: narrow stores on lanes, half/byte loads, truncated addresses
    beat(32, 32'h04, 4'b0100, 1'b1, 32'h00AB0000, 32'h0, 0);
    issue(32, 1'b1, 3'b000, 32'h06, 32'h123456AB, 32'h0, 1'b0, 1);
    beat(32, 32'h04, 4'b1100, 1'b0, 32'h0, 32'h98765432, 0);
    issue(32, 1'b0, 3'b101, 32'h06, 32'h0, 32'h00009876, 1'b0, 1);
    beat(32, 32'h04, 4'b1100, 1'b0, 32'h0, 32'h98765432, 0);
    issue(32, 1'b0, 3'b001, 32'h06, 32'h0, 32'hFFFF9876, 1'b0, 1);
    beat(32, 32'h00, 4'b1100, 1'b1, 32'h13570000, 32'h0, 0);
    issue(32, 1'b1, 3'b001, 32'h02, 32'hFFFF1357, 32'h0, 1'b0, 1);
    beat(32, 32'h04, 4'b1000, 1'b0, 32'h0, 32'h7F112233, 0);
    issue(32, 1'b0, 3'b000, 32'h07, 32'h0, 32'h0000007F, 1'b0, 1);
    beat(32, 32'h0008, 4'b1111, 1'b0, 32'h0, 32'hDEADBEEF, 0);
    issue(32, 1'b0, 3'b010, 32'h00010008, 32'h0, 32'hDEADBEEF, 1'b0, 1);
    beat(32, 32'h000C, 4'b1111, 1'b1, 32'h0BADF00D, 32'h0, 0);
    issue(32, 1'b1, 3'b010, 32'h1234000C, 32'h0BADF00D, 32'h0, 1'b0, 1);
    issue(32, 1'b1, 3'b010, 32'h0E, 32'h0BADF00D, 32'h0, 1'b1, 0);
    issue(32, 1'b0, 3'b110, 32'h08, 32'h0, 32'h0, 1'b1, 0);

    repeat (5) @(negedge clock);
    check("beats_drained", beats8.size() + beats32.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
